// File: rtl/log_pkg.sv
// Shared types for the log-domain to linear-domain conversion path.
// Widths here match the default parameters of log_to_linear_pipe.
package log_pkg;

    localparam int LOG_FRAC_BITS = 5;
    localparam int PKG_LOG_INT   = 6;
    localparam int PKG_EXP_WIDTH = 5;

    typedef struct packed {
        logic                                 sign;
        logic                                 zero;
        logic [PKG_LOG_INT+LOG_FRAC_BITS-1:0] log;
    } log_val_t;

    typedef struct packed {
        logic                     sign;
        logic                     zero;
        logic [PKG_EXP_WIDTH-1:0] exp;
        logic [LOG_FRAC_BITS-1:0] mant;
        logic                     ovf;
        logic                     unf;
    } lin_val_t;

endpackage

// File: rtl/pow2_lut_5x5.sv
// Fractional power-of-two ROM: out = round(32*(2^(in/32)-1)).
// Top entry stays at 31, so the mantissa never carries into the exponent.
module pow2_lut_5x5 (
    input  logic [4:0] in,
    output logic [4:0] out
);

    always_comb begin
        out = '0;
        unique case (in)
            5'd0:  out = 5'd0;
            5'd1:  out = 5'd1;
            5'd2:  out = 5'd1;
            5'd3:  out = 5'd2;
            5'd4:  out = 5'd3;
            5'd5:  out = 5'd4;
            5'd6:  out = 5'd4;
            5'd7:  out = 5'd5;
            5'd8:  out = 5'd6;
            5'd9:  out = 5'd7;
            5'd10: out = 5'd8;
            5'd11: out = 5'd9;
            5'd12: out = 5'd9;
            5'd13: out = 5'd10;
            5'd14: out = 5'd11;
            5'd15: out = 5'd12;
            5'd16: out = 5'd13;
            5'd17: out = 5'd14;
            5'd18: out = 5'd15;
            5'd19: out = 5'd16;
            5'd20: out = 5'd17;
            5'd21: out = 5'd18;
            5'd22: out = 5'd20;
            5'd23: out = 5'd21;
            5'd24: out = 5'd22;
            5'd25: out = 5'd23;
            5'd26: out = 5'd24;
            5'd27: out = 5'd25;
            5'd28: out = 5'd27;
            5'd29: out = 5'd28;
            5'd30: out = 5'd29;
            5'd31: out = 5'd31;
        endcase
    end

endmodule

// File: rtl/log_to_linear_pipe.sv
// Two-stage valid/ready converter from signed log2 fixed point to
// biased-exponent linear float, with saturating ovf/unf event counters.
module log_to_linear_pipe
    import log_pkg::*;
#(
    parameter int LOG_INT   = PKG_LOG_INT,
    parameter int EXP_WIDTH = PKG_EXP_WIDTH,
    parameter int BIAS      = 15,
    parameter int CNT_WIDTH = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_sign,
    input  logic                             in_zero,
    input  logic [LOG_INT+LOG_FRAC_BITS-1:0] in_log,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_sign,
    output logic                             out_zero,
    output logic [EXP_WIDTH-1:0]             out_exp,
    output logic [LOG_FRAC_BITS-1:0]         out_mant,
    output logic                             out_ovf,
    output logic                             out_unf,
    input  logic                             clear_counts,
    output logic [CNT_WIDTH-1:0]             ovf_count,
    output logic [CNT_WIDTH-1:0]             unf_count
);

    localparam int LW = LOG_INT + LOG_FRAC_BITS;
    localparam int EW = LOG_INT + 2;
    localparam logic signed [EW-1:0] EMAX =
        EW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [EW-1:0] EMIN = EW'(1);

    log_val_t                 in_beat;
    logic                     adv1;
    logic                     adv2;
    logic                     xfer;
    logic                     s1_valid;
    logic                     s1_sign;
    logic                     s1_zero;
    logic signed [EW-1:0]     s1_e;
    logic [LOG_FRAC_BITS-1:0] s1_mant;
    logic [LOG_FRAC_BITS-1:0] lut_mant;
    logic signed [EW-1:0]     e_in;
    logic                     s2_valid;
    lin_val_t                 s2_d;
    lin_val_t                 s2_q;

    assign in_beat  = '{sign: in_sign, zero: in_zero, log: in_log};

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign xfer     = s2_valid && out_ready;

    assign e_in = EW'($signed(in_beat.log[LW-1:LOG_FRAC_BITS]))
                + EW'(BIAS);

    pow2_lut_5x5 u_lut (
        .in  (in_beat.log[LOG_FRAC_BITS-1:0]),
        .out (lut_mant)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_e     <= '0;
            s1_mant  <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_beat.sign;
                s1_zero <= in_beat.zero;
                s1_e    <= e_in;
                s1_mant <= lut_mant;
            end
        end
    end

    // Zero input takes priority over any range decision on e.
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_sign;
        unique case (1'b1)
            s1_zero: begin
                s2_d.zero = 1'b1;
            end
            (!s1_zero && (s1_e > EMAX)): begin
                s2_d.exp  = '1;
                s2_d.mant = '1;
                s2_d.ovf  = 1'b1;
            end
            (!s1_zero && (s1_e < EMIN)): begin
                s2_d.zero = 1'b1;
                s2_d.unf  = 1'b1;
            end
            default: begin
                s2_d.exp  = s1_e[EXP_WIDTH-1:0];
                s2_d.mant = s1_mant;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_sign  = s2_q.sign;
    assign out_zero  = s2_q.zero;
    assign out_exp   = s2_q.exp;
    assign out_mant  = s2_q.mant;
    assign out_ovf   = s2_q.ovf;
    assign out_unf   = s2_q.unf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else if (clear_counts) begin
            ovf_count <= '0;
            unf_count <= '0;
        end else begin
            if (xfer && s2_q.ovf && (ovf_count != '1)) begin
                ovf_count <= ovf_count + CNT_WIDTH'(1);
            end
            if (xfer && s2_q.unf && (unf_count != '1)) begin
                unf_count <= unf_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_log_to_linear_pipe.sv
// Randomized bench for log_to_linear_pipe against an arithmetic
// reference model, with a CNT_WIDTH=2 twin for counter saturation.
module tb_log_to_linear_pipe;

    typedef struct packed {
        logic       s;
        logic       z;
        logic [4:0] e;
        logic [4:0] m;
        logic       o;
        logic       u;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sign = 1'b0;
    logic        in_zero = 1'b0;
    logic [10:0] in_log = '0;
    logic        out_ready = 1'b1;
    logic        clear_counts = 1'b0;

    logic        in_ready, out_valid;
    logic        out_sign, out_zero, out_ovf, out_unf;
    logic [4:0]  out_exp, out_mant;
    logic [15:0] ovf_count, unf_count;

    logic        in_ready2, out_valid2;
    logic        out_sign2, out_zero2, out_ovf2, out_unf2;
    logic [4:0]  out_exp2, out_mant2;
    logic [1:0]  ovf_count2, unf_count2;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_total = 0;
    int   mo1 = 0, mu1 = 0, mo2 = 0, mu2 = 0;
    bit   done = 1'b0;
    exp_t q[$];
    int   tq[$];

    always #5 clock = ~clock;

    log_to_linear_pipe dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_zero(in_zero), .in_log(in_log),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_zero(out_zero),
        .out_exp(out_exp), .out_mant(out_mant),
        .out_ovf(out_ovf), .out_unf(out_unf),
        .clear_counts(clear_counts),
        .ovf_count(ovf_count), .unf_count(unf_count)
    );

    log_to_linear_pipe #(.CNT_WIDTH(2)) dut2 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_sign(in_sign), .in_zero(in_zero), .in_log(in_log),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_sign(out_sign2), .out_zero(out_zero2),
        .out_exp(out_exp2), .out_mant(out_mant2),
        .out_ovf(out_ovf2), .out_unf(out_unf2),
        .clear_counts(clear_counts),
        .ovf_count(ovf_count2), .unf_count(unf_count2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, req, $time);
        end
    endtask

    function automatic int lut_ref(input int f);
        real r;
        r = $pow(2.0, real'(f) / 32.0);
        return int'($floor(32.0 * (r - 1.0) + 0.5));
    endfunction

    function automatic exp_t model(input logic s, input logic z,
                                   input logic [10:0] l);
        exp_t r;
        int   i, e, m;
        i = int'($signed(l[10:5]));
        e = i + 15;
        r = '0;
        r.s = s;
        if (z) begin
            r.z = 1'b1;
        end else if (e > 31) begin
            r.e = 5'd31;
            r.m = 5'd31;
            r.o = 1'b1;
        end else if (e < 1) begin
            r.z = 1'b1;
            r.u = 1'b1;
        end else begin
            m = lut_ref(int'(l[4:0]));
            r.e = e[4:0];
            r.m = m[4:0];
        end
        return r;
    endfunction

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        int   n;
        bit   exp_rdy, exp_v;
        exp_t f;
        if (reset) begin
            q.delete();
            tq.delete();
            mo1 = 0; mu1 = 0; mo2 = 0; mu2 = 0;
        end else begin
            n = q.size();
            exp_rdy = !(n == 2 && !out_ready);
            exp_v = (n > 0) && (cyc >= tq[0] + 2);
            chk("in_ready", in_ready, exp_rdy);
            chk("in_ready2", in_ready2, exp_rdy);
            chk("out_valid", out_valid, exp_v);
            chk("out_valid2", out_valid2, exp_v);
            if (exp_v) begin
                chk("out_data", {out_sign, out_zero, out_exp,
                    out_mant, out_ovf, out_unf}, q[0]);
                chk("out_data2", {out_sign2, out_zero2, out_exp2,
                    out_mant2, out_ovf2, out_unf2}, q[0]);
            end
            chk("ovf_count", ovf_count, mo1);
            chk("unf_count", unf_count, mu1);
            chk("ovf_count2", ovf_count2, mo2);
            chk("unf_count2", unf_count2, mu2);
            if (exp_v && out_ready) begin
                f = q.pop_front();
                void'(tq.pop_front());
                if (f.o) begin
                    if (mo1 < 65535) mo1++;
                    if (mo2 < 3) mo2++;
                end
                if (f.u) begin
                    if (mu1 < 65535) mu1++;
                    if (mu2 < 3) mu2++;
                end
            end
            if (clear_counts) begin
                mo1 = 0; mu1 = 0; mo2 = 0; mu2 = 0;
            end
            if (in_valid && exp_rdy) begin
                q.push_back(model(in_sign, in_zero, in_log));
                tq.push_back(cyc);
                acc_total++;
            end
        end
    end

    task automatic send(input logic s, input logic z,
                        input logic [10:0] l);
        int b;
        bit acc;
        in_valid = 1'b1;
        in_sign = s;
        in_zero = z;
        in_log = l;
        b = 0;
        acc = 1'b0;
        do begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            b++;
        end while (!acc && b < 200);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input logic s, input logic [10:0] l,
                            input exp_t req, input string nm);
        send(s, 1'b0, l);
        @(posedge clock);
        #1;
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk(nm, {out_sign, out_zero, out_exp, out_mant,
                 out_ovf, out_unf}, req);
    endtask

    initial begin
        exp_t m;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_ovf_count", ovf_count, 0);
        chk("rst_unf_count", unf_count, 0);
        chk("rst_out_data", {out_sign, out_zero, out_exp, out_mant,
                             out_ovf, out_unf}, 0);

        chk("lut_0", lut_ref(0), 0);
        chk("lut_1", lut_ref(1), 1);
        chk("lut_8", lut_ref(8), 6);
        chk("lut_12", lut_ref(12), 9);
        chk("lut_16", lut_ref(16), 13);
        chk("lut_22", lut_ref(22), 20);
        chk("lut_24", lut_ref(24), 22);
        chk("lut_31", lut_ref(31), 31);
        m = model(1'b0, 1'b0, {6'd0, 5'd0});
        chk("model_unity", m, {1'b0, 1'b0, 5'd15, 5'd0, 2'b00});
        m = model(1'b1, 1'b0, {6'd17, 5'd3});
        chk("model_ovf", m, {1'b1, 1'b0, 5'd31, 5'd31, 2'b10});
        m = model(1'b0, 1'b0, {6'b110001, 5'd9});
        chk("model_unf", m, {1'b0, 1'b1, 5'd0, 5'd0, 2'b01});

        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;

        directed(1'b0, {6'd0, 5'd0},
                 {1'b0, 1'b0, 5'd15, 5'd0, 2'b00}, "unity");
        directed(1'b1, {6'd3, 5'd16},
                 {1'b1, 1'b0, 5'd18, 5'd13, 2'b00}, "pos_int");
        directed(1'b0, {6'b111110, 5'd31},
                 {1'b0, 1'b0, 5'd13, 5'd31, 2'b00}, "neg_int");
        directed(1'b0, {6'd17, 5'd0},
                 {1'b0, 1'b0, 5'd31, 5'd31, 2'b10}, "ovf");
        @(posedge clock);
        #1 chk("ovf_count_1", ovf_count, 1);
        directed(1'b0, {6'b110001, 5'd0},
                 {1'b0, 1'b1, 5'd0, 5'd0, 2'b01}, "unf");
        @(posedge clock);
        #1 chk("unf_count_1", unf_count, 1);

        // Stall: only two beats fit while the output is blocked.
        out_ready = 1'b0;
        begin
            int a0;
            a0 = acc_total;
            fork
                begin
                    for (int i = 0; i < 6; i++)
                        send(1'b0, 1'b0, {6'(i), 5'(i * 5)});
                end
                begin
                    repeat (4) @(posedge clock);
                    #1;
                    chk("stall_accepts", acc_total - a0, 2);
                    chk("stall_in_ready", in_ready, 1'b0);
                    chk("stall_out_valid", out_valid, 1'b1);
                    chk("stall_held_exp", out_exp, 5'd15);
                    out_ready = 1'b1;
                end
            join
        end
        repeat (4) @(posedge clock);
        #1;

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(1'b0, 1'b0, {6'd2, 5'd1});
        send(1'b1, 1'b0, {6'd20, 5'd1});
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_ovf_count", ovf_count, 0);
        chk("mid_rst_unf_count", unf_count, 0);
        chk("mid_rst_out_exp", out_exp, 0);
        @(negedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        directed(1'b1, {6'd1, 5'd8},
                 {1'b1, 1'b0, 5'd16, 5'd6, 2'b00}, "post_rst");

        // Saturation of the narrow counter, then clear on a transfer.
        for (int i = 0; i < 5; i++)
            send(1'b0, 1'b0, {6'd20, 5'(i)});
        repeat (3) @(posedge clock);
        #1;
        chk("sat_ovf_count2", ovf_count2, 2'd3);
        chk("sat_ovf_count", ovf_count, 5);
        send(1'b0, 1'b0, {6'd25, 5'd0});
        @(posedge clock);
        #1;
        chk("clr_xfer_valid", out_valid & out_ovf, 1'b1);
        clear_counts = 1'b1;
        @(posedge clock);
        #1;
        clear_counts = 1'b0;
        chk("clr_ovf_count", ovf_count, 0);
        chk("clr_ovf_count2", ovf_count2, 0);

        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    send(1'($urandom), 1'($urandom_range(0, 7) == 0),
                         11'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clock);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    clear_counts = ($urandom_range(0, 15) == 0);
                end
            end
        join
        out_ready = 1'b1;
        clear_counts = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("drained", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
